// File: rtl/spi_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spi_sram_responder                                               |
// | Brief   : SPI mode-0 responder emulating a 23LC-style serial SRAM          |
// |           (READ 0x03 / WRITE 0x02, 24-bit address, sequential mode),       |
// |           oversampled in the clk domain, backed by a synchronous byte RAM. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spi_sram_responder #(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_cmd    = 3'd1;
  localparam logic [2:0] c_st_addr   = 3'd2;
  localparam logic [2:0] c_st_rdata  = 3'd3;
  localparam logic [2:0] c_st_wdata  = 3'd4;
  localparam logic [2:0] c_st_ignore = 3'd5;

  localparam logic [7:0]        c_cmd_read  = 8'h03;
  localparam logic [7:0]        c_cmd_write = 8'h02;
  localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_q;
  logic                   r_cs_q;

  logic [2:0]        r_state;
  logic [2:0]        r_bit_cnt;
  logic [1:0]        r_byte_cnt;
  logic [2:0]        r_fall_cnt;
  logic [7:0]        r_shift_in;
  logic [7:0]        r_shift_out;
  logic              r_is_write;
  logic              r_rd_capture;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_miso;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_cmd_err;

  logic       w_sck_s;
  logic       w_cs_s;
  logic       w_mosi_s;
  logic       w_rise;
  logic       w_fall;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic [7:0] w_byte_in;

  assign w_sck_s   = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sck_s & ~r_sck_q & ~w_cs_s;
  assign w_fall    = ~w_sck_s & r_sck_q & ~w_cs_s;
  assign w_cs_fall = ~w_cs_s & r_cs_q;
  assign w_cs_rise = w_cs_s & ~r_cs_q;
  assign w_byte_in = {r_shift_in[6:0], w_mosi_s};

  // Chains preset to the idle bus levels so reset release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_q     <= 1'b0;
      r_cs_q      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sck_q     <= w_sck_s;
      r_cs_q      <= w_cs_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= c_st_idle;
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= 2'd0;
      r_fall_cnt   <= 3'd0;
      r_shift_in   <= 8'h00;
      r_shift_out  <= 8'h00;
      r_is_write   <= 1'b0;
      r_rd_capture <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 8'h00;
      r_miso       <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_rd_capture <= r_mem_rd;

      // Post-increment after the write strobe has been seen with the old address.
      if (r_mem_wr) begin
        r_addr <= r_addr + c_addr_one;
      end

      if (w_cs_rise) begin
        r_state <= c_st_idle;
        r_miso  <= 1'b0;
      end else if (w_cs_fall) begin
        r_state    <= c_st_cmd;
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= 2'd0;
        r_miso     <= 1'b0;
      end else begin
        if (w_rise) begin
          r_shift_in <= w_byte_in;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end

        case (r_state)
          c_st_idle: begin
            r_miso <= 1'b0;
          end
          c_st_cmd: begin
            if (w_rise && r_bit_cnt == 3'd7) begin
              if (w_byte_in == c_cmd_read) begin
                r_is_write <= 1'b0;
                r_state    <= c_st_addr;
              end else if (w_byte_in == c_cmd_write) begin
                r_is_write <= 1'b1;
                r_state    <= c_st_addr;
              end else begin
                r_cmd_err <= 1'b1;
                r_state   <= c_st_ignore;
              end
            end
          end
          c_st_addr: begin
            if (w_rise) begin
              r_addr <= {r_addr[ADDR_W-2:0], w_mosi_s};
              // Command is byte 0, so the last address bit lands in byte 3.
              if (r_bit_cnt == 3'd7 && r_byte_cnt == 2'd3) begin
                if (r_is_write) begin
                  r_state <= c_st_wdata;
                end else begin
                  r_mem_rd   <= 1'b1;
                  r_fall_cnt <= 3'd0;
                  r_state    <= c_st_rdata;
                end
              end
            end
          end
          c_st_rdata: begin
            if (r_rd_capture) begin
              r_shift_out <= mem_rdata;
            end else if (w_fall) begin
              r_miso      <= r_shift_out[7];
              r_shift_out <= {r_shift_out[6:0], 1'b0};
              r_fall_cnt  <= r_fall_cnt + 3'd1;
              if (r_fall_cnt == 3'd7) begin
                r_addr   <= r_addr + c_addr_one;
                r_mem_rd <= 1'b1;
              end
            end
          end
          c_st_wdata: begin
            if (w_rise && r_bit_cnt == 3'd7) begin
              r_wdata  <= w_byte_in;
              r_mem_wr <= 1'b1;
            end
          end
          c_st_ignore: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= c_st_idle;
          end
        endcase
      end
    end
  end

  assign miso      = r_miso;
  assign miso_oe   = ~w_cs_s;
  assign mem_addr  = r_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != c_st_idle);
  assign cmd_err   = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_spi_sram_responder                                            |
// | Brief   : Directed bench for spi_sram_responder with a backing-RAM model   |
// |           and write/read scoreboards.                                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_spi_sram_responder;

  localparam int ADDR_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF_SCK    = 8;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              cmd_err;

  logic [7:0] mem [0:65535];
  wr_t        wr_exp[$];
  logic [7:0] rd_exp[$];

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int err_seen = 0;

  spi_sram_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every write must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd) rd_seen++;
      if (cmd_err) err_seen++;
      if (mem_rd || mem_wr) check("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
      if (mem_wr) begin
        wr_seen++;
        check("wr_expected", {31'd0, wr_exp.size() != 0}, 32'd1);
        if (wr_exp.size() != 0) begin
          wr_t e;
          e = wr_exp.pop_front();
          check("wr_addr", {16'd0, mem_addr}, {16'd0, e.a});
          check("wr_data", {24'd0, mem_wdata}, {24'd0, e.d});
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    wait_clk(HALF_SCK);
    sck = 1'b1;
    r = miso;
    wait_clk(HALF_SCK);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] r;
    spi_byte(b, r);
  endtask

  task automatic recv_check(input string tag);
    logic [7:0] r;
    logic [7:0] e;
    spi_byte(8'h00, r);
    e = rd_exp.pop_front();
    check(tag, {24'd0, r}, {24'd0, e});
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    wait_clk(HALF_SCK);
  endtask

  task automatic cs_end();
    wait_clk(HALF_SCK);
    cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    send(cmd);
    send(a[23:16]);
    send(a[15:8]);
    send(a[7:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int rd0;
    int err0;
    int k;
    logic r;

    reset = 1'b1;
    sck   = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    wait_clk(5);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    reset = 1'b0;
    wait_clk(5);

    // Reset asserted in the middle of the address phase.
    cs_start();
    send(8'h02);
    send(8'h00);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    wait_clk(2);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_miso", {31'd0, miso}, 32'd0);
    check("midrst_oe", {31'd0, miso_oe}, 32'd0);
    check("midrst_addr", {16'd0, mem_addr}, 32'd0);
    check("midrst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("midrst_strobes", {29'd0, mem_rd, mem_wr, cmd_err}, 32'd0);
    cs_n = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(6);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    wr0 = wr_seen;
    wr_exp.push_back('{a: 16'h0030, d: 8'hC3});
    cs_start();
    send_hdr(8'h02, 24'h000030);
    send(8'hC3);
    cs_end();
    check("post_rst_wr_count", wr_seen - wr0, 32'd1);

    // Sequential write.
    wr0 = wr_seen;
    wr_exp.push_back('{a: 16'h0010, d: 8'hA5});
    wr_exp.push_back('{a: 16'h0011, d: 8'h5A});
    cs_start();
    send_hdr(8'h02, 24'h000010);
    send(8'hA5);
    send(8'h5A);
    cs_end();
    check("write_count", wr_seen - wr0, 32'd2);
    check("write_idle", {31'd0, busy}, 32'd0);

    // Sequential read from a preloaded model.
    mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h5A;
    rd_exp.push_back(8'hA5);
    rd_exp.push_back(8'h5A);
    cs_start();
    send(8'h03);
    check("read_busy", {31'd0, busy}, 32'd1);
    check("read_oe", {31'd0, miso_oe}, 32'd1);
    send(8'h00);
    send(8'h00);
    send(8'h10);
    recv_check("read_b0");
    recv_check("read_b1");
    cs_end();
    check("read_oe_off", {31'd0, miso_oe}, 32'd0);
    check("read_miso_off", {31'd0, miso}, 32'd0);

    // Address wrap on write then read.
    wr0 = wr_seen;
    wr_exp.push_back('{a: 16'hFFFF, d: 8'h11});
    wr_exp.push_back('{a: 16'h0000, d: 8'h22});
    cs_start();
    send_hdr(8'h02, 24'h00FFFF);
    send(8'h11);
    send(8'h22);
    cs_end();
    check("wrap_wr_count", wr_seen - wr0, 32'd2);
    rd_exp.push_back(8'h11);
    rd_exp.push_back(8'h22);
    cs_start();
    send_hdr(8'h03, 24'h00FFFF);
    recv_check("wrap_rd_b0");
    recv_check("wrap_rd_b1");
    cs_end();

    // Partial data byte then deselect.
    wr0 = wr_seen;
    cs_start();
    send_hdr(8'h02, 24'h000020);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    wait_clk(HALF_SCK);
    cs_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!busy && k == 0) k = i;
    end
    check("abort_busy_drop", {31'd0, (k != 0) && (k <= SYNC_STAGES + 2)}, 32'd1);
    check("abort_no_wr", wr_seen - wr0, 32'd0);

    // Unsupported command.
    wr0 = wr_seen;
    rd0 = rd_seen;
    err0 = err_seen;
    cs_start();
    send(8'hFF);
    for (int i = 0; i < 8; i++) begin
      rd_exp.push_back(8'h00);
      recv_check("badcmd_miso");
    end
    cs_end();
    check("badcmd_err_count", err_seen - err0, 32'd1);
    check("badcmd_no_rd", rd_seen - rd0, 32'd0);
    check("badcmd_no_wr", wr_seen - wr0, 32'd0);
    rd_exp.push_back(8'hA5);
    cs_start();
    send_hdr(8'h03, 24'h000010);
    recv_check("after_bad_read");
    cs_end();

    check("wr_queue_drained", wr_exp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
